// File: rtl/button_conditioner_if.sv
// Pushbutton conditioner bus: raw pins in, debounced level and event pulses out.
interface button_conditioner_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;

    // Board / stimulus side: drives the pins, observes the conditioned outputs
    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    // Conditioner side
    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-button pushbutton conditioner: 2-flop synchronizer, counter debounce,
// one-cycle press/release pulses and optional hold-to-repeat press pulses.
// Every button is an independent copy of the same logic.
module button_conditioner #(
    parameter int N_BTN         = 5,
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 20_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    button_conditioner_if.slave   btn_if
);

    // Debounce counter only has to reach STABLE_CYCLES-1
    localparam int DCNT_W = $clog2(STABLE_CYCLES);
    localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(STABLE_CYCLES - 1);

    // Repeat counter is shared between the initial delay and the period
    localparam int RCNT_TOP = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCNT_W   = $clog2(RCNT_TOP);
    localparam logic [RCNT_W-1:0] DELAY_MAX  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] PERIOD_MAX = RCNT_W'(REPEAT_PERIOD - 1);
    localparam bit REPEAT_ON = (REPEAT_EN != 0);

    typedef enum logic [1:0] {
        RELEASED,
        HELD_WAIT,
        HELD_REPEAT
    } rstate_e;

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [N_BTN-1:0] level_w;
    logic [N_BTN-1:0] press_w;
    logic [N_BTN-1:0] release_w;

    // Two-flop synchronizer for the asynchronous pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_if.btn_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic              level_q, level_d;
        logic              press_q, press_d;
        logic              release_q, release_d;
        logic [DCNT_W-1:0] dcnt_q, dcnt_d;
        logic [RCNT_W-1:0] rcnt_q, rcnt_d;
        rstate_e           state_q, state_d;
        logic              rise, fall;

        // Debounce: accept the new level after STABLE_CYCLES disagreeing samples in a row
        always_comb begin
            level_d = level_q;
            dcnt_d  = dcnt_q;
            rise    = 1'b0;
            fall    = 1'b0;
            if (sync2_q[i] == level_q) begin
                dcnt_d = '0;
            end else if (dcnt_q == DCNT_MAX) begin
                level_d = ~level_q;
                dcnt_d  = '0;
                rise    = ~level_q;
                fall    = level_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end

        // Repeat FSM: a fall always wins over a repeat firing on the same edge
        always_comb begin
            state_d   = state_q;
            rcnt_d    = rcnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            if (fall) begin
                release_d = 1'b1;
                rcnt_d    = '0;
                state_d   = RELEASED;
            end else begin
                unique case (state_q)
                    RELEASED: begin
                        if (rise) begin
                            press_d = 1'b1;
                            rcnt_d  = '0;
                            state_d = HELD_WAIT;
                        end
                    end
                    HELD_WAIT: begin
                        // Without repeat the counter parks at the delay limit instead of wrapping
                        if (rcnt_q == DELAY_MAX) begin
                            if (REPEAT_ON) begin
                                press_d = 1'b1;
                                rcnt_d  = '0;
                                state_d = HELD_REPEAT;
                            end
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                    HELD_REPEAT: begin
                        if (rcnt_q == PERIOD_MAX) begin
                            press_d = 1'b1;
                            rcnt_d  = '0;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                    default: begin
                        rcnt_d  = '0;
                        state_d = RELEASED;
                    end
                endcase
            end
        end

        // State and registered outputs; reset discards any debounce/repeat progress silently
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                dcnt_q    <= '0;
                rcnt_q    <= '0;
                state_q   <= RELEASED;
            end else begin
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                dcnt_q    <= dcnt_d;
                rcnt_q    <= rcnt_d;
                state_q   <= state_d;
            end
        end

        assign level_w[i]   = level_q;
        assign press_w[i]   = press_q;
        assign release_w[i] = release_q;
    end

    assign btn_if.btn_level   = level_w;
    assign btn_if.btn_press   = press_w;
    assign btn_if.btn_release = release_w;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: one instance without repeat and one
// with repeat enabled. Stimulus pushes expected pulse events (cycle, press, release);
// monitors pop and compare whenever an instance shows any pulse.
module tb_button_conditioner;

    localparam int N = 5;
    localparam int S = 4;
    localparam int D = 20;
    localparam int P = 8;

    typedef struct {
        int         cyc;
        logic [4:0] press;
        logic [4:0] rel;
    } evt_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    evt_t q0[$];
    evt_t q1[$];

    button_conditioner_if #(.N_BTN(N)) if0 ();
    button_conditioner_if #(.N_BTN(N)) if1 ();

    button_conditioner #(
        .N_BTN(N), .STABLE_CYCLES(S), .REPEAT_EN(0),
        .REPEAT_DELAY(D), .REPEAT_PERIOD(P)
    ) u_norep (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_if (if0.slave)
    );

    button_conditioner #(
        .N_BTN(N), .STABLE_CYCLES(S), .REPEAT_EN(1),
        .REPEAT_DELAY(D), .REPEAT_PERIOD(P)
    ) u_rep (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_if (if1.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input int id, input int c, input logic [4:0] pr, input logic [4:0] rl);
        evt_t e;
        e.cyc = c;
        e.press = pr;
        e.rel = rl;
        if (id == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic mon(input int id, input logic [4:0] pr, input logic [4:0] rl);
        evt_t e;
        int   empty;
        empty = (id == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse dut%0d: got press=%0h release=%0h expected none (cycle %0d)",
                     id, pr, rl, cyc);
        end else begin
            e = (id == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("dut%0d_evt_cycle", id), cyc, e.cyc);
            chk($sformatf("dut%0d_press", id), int'(pr), int'(e.press));
            chk($sformatf("dut%0d_release", id), int'(rl), int'(e.rel));
        end
    endtask

    // Monitors: sample on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ((if0.btn_press | if0.btn_release) != 5'h00))
            mon(0, if0.btn_press, if0.btn_release);
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ((if1.btn_press | if1.btn_release) != 5'h00))
            mon(1, if1.btn_press, if1.btn_release);
    end

    initial begin
        int base;
        rst_n = 1'b0;
        if0.btn_raw = 5'h1F;
        if1.btn_raw = 5'h00;

        // Reset held with all buttons pressed
        step(10);
        chk("rst_level", int'(if0.btn_level), 0);
        chk("rst_press", int'(if0.btn_press), 0);
        chk("rst_release", int'(if0.btn_release), 0);
        step(10);
        chk("rst_level_late", int'(if0.btn_level), 0);
        rst_n = 1'b1;
        push(0, cyc + 6, 5'h1F, 5'h00);
        step(5);
        chk("rst_exit_level_pre", int'(if0.btn_level), 0);
        step(1);
        chk("rst_exit_level", int'(if0.btn_level), 'h1F);
        if0.btn_raw = 5'h00;
        push(0, cyc + 6, 5'h00, 5'h1F);
        step(10);

        // Clean press and long hold without repeat
        if0.btn_raw = 5'h01;
        push(0, cyc + 6, 5'h01, 5'h00);
        step(5);
        chk("press_level_pre", int'(if0.btn_level), 0);
        step(1);
        chk("press_level", int'(if0.btn_level), 'h01);
        step(94);
        if0.btn_raw = 5'h00;
        push(0, cyc + 6, 5'h00, 5'h01);
        step(5);
        chk("release_level_pre", int'(if0.btn_level), 'h01);
        step(1);
        chk("release_level", int'(if0.btn_level), 0);
        step(8);

        // Bouncing input, then settle high
        for (int i = 0; i < 10; i++) begin
            if0.btn_raw = (i % 2 == 0) ? 5'h04 : 5'h00;
            step(2);
        end
        chk("bounce_level", int'(if0.btn_level), 0);
        if0.btn_raw = 5'h04;
        push(0, cyc + 6, 5'h04, 5'h00);
        step(5);
        chk("bounce_settle_pre", int'(if0.btn_level), 0);
        step(1);
        chk("bounce_settle", int'(if0.btn_level), 'h04);
        step(4);
        if0.btn_raw = 5'h00;
        push(0, cyc + 6, 5'h00, 5'h04);
        step(10);

        // Three-cycle glitch is rejected
        if0.btn_raw = 5'h08;
        step(3);
        if0.btn_raw = 5'h00;
        step(12);
        chk("glitch_level", int'(if0.btn_level), 0);

        // Simultaneous press on two buttons, independent release
        if0.btn_raw = 5'h11;
        push(0, cyc + 6, 5'h11, 5'h00);
        step(10);
        if0.btn_raw = 5'h01;
        push(0, cyc + 6, 5'h00, 5'h10);
        step(6);
        chk("indep_level", int'(if0.btn_level), 'h01);
        step(4);
        if0.btn_raw = 5'h00;
        push(0, cyc + 6, 5'h00, 5'h01);
        step(10);

        // Hold-to-repeat; the fall lands on the edge the next repeat would fire
        if1.btn_raw = 5'h02;
        base = cyc + 6;
        push(1, base,      5'h02, 5'h00);
        push(1, base + 20, 5'h02, 5'h00);
        push(1, base + 28, 5'h02, 5'h00);
        push(1, base + 36, 5'h02, 5'h00);
        push(1, base + 44, 5'h02, 5'h00);
        push(1, base + 52, 5'h02, 5'h00);
        push(1, base + 60, 5'h00, 5'h02);
        step(60);
        if1.btn_raw = 5'h00;
        step(6);
        chk("repeat_fall_level", int'(if1.btn_level), 0);
        step(30);

        // Asynchronous reset during HELD_REPEAT, button kept held
        if1.btn_raw = 5'h02;
        base = cyc + 6;
        push(1, base,      5'h02, 5'h00);
        push(1, base + 20, 5'h02, 5'h00);
        push(1, base + 28, 5'h02, 5'h00);
        step(36);
        chk("pre_reset_level", int'(if1.btn_level), 'h02);
        rst_n = 1'b0;
        #1;
        chk("async_rst_level", int'(if1.btn_level), 0);
        chk("async_rst_press", int'(if1.btn_press), 0);
        chk("async_rst_release", int'(if1.btn_release), 0);
        step(3);
        rst_n = 1'b1;
        base = cyc;
        push(1, base + 6,  5'h02, 5'h00);
        push(1, base + 26, 5'h02, 5'h00);
        push(1, base + 34, 5'h02, 5'h00);
        step(30);
        if1.btn_raw = 5'h00;
        push(1, cyc + 6, 5'h00, 5'h02);
        step(15);

        chk("dut0_pending", q0.size(), 0);
        chk("dut1_pending", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
